// File: rtl/param_cpu_core_if.sv
// Instruction-fetch handshake between the core and its instruction memory.
// The core holds req/addr until valid is returned; rdata is qualified by valid.
interface param_cpu_core_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 15
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/param_cpu_core.sv
// Parametrised multi-cycle CPU core: FETCH/EXEC/HALT state machine, one
// instruction per fetch handshake, N/C/Z flags and a debug register read port.
module param_cpu_core #(
    parameter int  DATA_W  = 8,
    parameter int  NREGS   = 8,
    parameter int  PC_W    = 8,
    parameter int  IMM_W   = 8,
    localparam int RA_W    = $clog2(NREGS),
    localparam int INSTR_W = 4 + RA_W + IMM_W
) (
    input  logic              clk,
    input  logic              reset_n,
    param_cpu_core_if.master  imem,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              illegal,
    output logic              halted,
    output logic [2:0]        flags,
    input  logic [RA_W-1:0]   dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t                         state_q, state_d;
    logic                           req_q, req_d;
    logic [INSTR_W-1:0]             ir_q, ir_d;
    logic [PC_W-1:0]                pc_q, pc_d;
    logic [NREGS-1:0][DATA_W-1:0]   regs_q, regs_d;
    logic [2:0]                     flags_q, flags_d;
    logic                           retire_q, retire_d;
    logic                           illegal_q, illegal_d;
    logic                           halted_q, halted_d;

    logic [3:0]                     op;
    logic [RA_W-1:0]                rd, rs;
    logic [IMM_W-1:0]               imm;
    logic [DATA_W+IMM_W-1:0]        imm_wide;
    logic [DATA_W-1:0]              a, b, res;
    logic [DATA_W:0]                sum, dif;
    logic [2*DATA_W-1:0]            prod;
    logic                           carry, wr_en, flag_en, take_jmp, is_halt, is_ill;

    assign op       = ir_q[INSTR_W-1 -: 4];
    assign rd       = ir_q[IMM_W +: RA_W];
    assign imm      = ir_q[IMM_W-1:0];
    assign rs       = imm[RA_W-1:0];
    assign imm_wide = {{DATA_W{1'b0}}, imm};
    assign a        = regs_q[rd];
    assign b        = regs_q[rs];
    assign sum      = {1'b0, a} + {1'b0, b};
    assign dif      = {1'b0, a} - {1'b0, b};
    assign prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    // Decode is evaluated every cycle but only acted on in EXEC.
    always_comb begin
        res      = '0;
        carry    = 1'b0;
        wr_en    = 1'b0;
        flag_en  = 1'b0;
        take_jmp = 1'b0;
        is_halt  = 1'b0;
        is_ill   = 1'b0;
        case (op)
            4'h0: begin res = sum[DATA_W-1:0]; carry = sum[DATA_W]; wr_en = 1'b1; flag_en = 1'b1; end
            4'h1: begin res = dif[DATA_W-1:0]; carry = dif[DATA_W]; wr_en = 1'b1; flag_en = 1'b1; end
            4'h2: begin
                res = prod[DATA_W-1:0]; carry = |prod[2*DATA_W-1:DATA_W];
                wr_en = 1'b1; flag_en = 1'b1;
            end
            4'h3: begin res = a & b; wr_en = 1'b1; flag_en = 1'b1; end
            4'h4: begin res = a | b; wr_en = 1'b1; flag_en = 1'b1; end
            4'h5: begin res = a ^ b; wr_en = 1'b1; flag_en = 1'b1; end
            4'h6: begin res = ~a;    wr_en = 1'b1; flag_en = 1'b1; end
            4'h7: begin res = b;     wr_en = 1'b1; end
            4'h8: begin res = imm_wide[DATA_W-1:0]; wr_en = 1'b1; end
            4'h9: begin res = dif[DATA_W-1:0]; carry = dif[DATA_W]; flag_en = 1'b1; end
            4'hA: take_jmp = 1'b1;
            4'hB: take_jmp = flags_q[0];
            4'hC: take_jmp = ~flags_q[0];
            4'hF: is_halt = 1'b1;
            default: is_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_d     = 1'b0;
        ir_d      = ir_q;
        pc_d      = pc_q;
        regs_d    = regs_q;
        flags_d   = flags_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        halted_d  = halted_q;
        case (state_q)
            S_FETCH: begin
                // req_q is low for the first cycle out of reset, so valid is ignored then.
                req_d = 1'b1;
                if (req_q && imem.imem_valid) begin
                    ir_d    = imem.imem_rdata;
                    state_d = S_EXEC;
                    req_d   = 1'b0;
                end
            end
            S_EXEC: begin
                retire_d  = 1'b1;
                illegal_d = is_ill;
                if (wr_en)   regs_d[rd] = res;
                if (flag_en) flags_d = {res[DATA_W-1], carry, res == '0};
                if (is_halt) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    pc_d    = take_jmp ? imm[PC_W-1:0] : pc_q + PC_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            req_q     <= 1'b0;
            ir_q      <= '0;
            pc_q      <= '0;
            regs_q    <= '0;
            flags_q   <= '0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            regs_q    <= regs_d;
            flags_q   <= flags_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign retire         = retire_q;
    assign illegal        = illegal_q;
    assign halted         = halted_q;
    assign flags          = flags_q;
    assign dbg_rdata      = regs_q[dbg_raddr];
endmodule

// File: tb/tb_param_cpu_core.sv
// Bench for param_cpu_core: 8-bit and 16-bit instances fed by behavioural
// instruction memories; retire records are checked against a scoreboard queue.
module tb_param_cpu_core;
    logic        clk = 1'b0;
    logic        rst8_n = 1'b0, rst16_n = 1'b0;
    logic [2:0]  dbg8 = '0;
    logic [3:0]  dbg16 = '0;
    logic [7:0]  pc8, pc16, rdata8;
    logic [15:0] rdata16;
    logic        retire8, ill8, halted8, retire16, ill16, halted16;
    logic [2:0]  flags8, flags16;
    int          n_tests = 0, n_fail = 0;
    int          dly8 = 0, cnt8 = 0;
    logic [7:0]  a0_8;
    logic [14:0] mem8 [256];
    logic [15:0] mem16 [256];
    logic [11:0] q8 [$];
    logic [11:0] q16 [$];
    logic [11:0] e8, e16;

    always #5 clk = ~clk;

    param_cpu_core_if #(.PC_W(8), .INSTR_W(15)) if8 ();
    param_cpu_core_if #(.PC_W(8), .INSTR_W(16)) if16 ();

    param_cpu_core #(.DATA_W(8), .NREGS(8), .PC_W(8), .IMM_W(8)) dut8 (
        .clk(clk), .reset_n(rst8_n), .imem(if8), .pc(pc8), .retire(retire8),
        .illegal(ill8), .halted(halted8), .flags(flags8), .dbg_raddr(dbg8), .dbg_rdata(rdata8));

    param_cpu_core #(.DATA_W(16), .NREGS(16), .PC_W(8), .IMM_W(8)) dut16 (
        .clk(clk), .reset_n(rst16_n), .imem(if16), .pc(pc16), .retire(retire16),
        .illegal(ill16), .halted(halted16), .flags(flags16), .dbg_raddr(dbg16), .dbg_rdata(rdata16));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] i8(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [15:0] i16(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic push8(input logic ill, input logic [2:0] f, input logic [7:0] p);
        q8.push_back({ill, f, p});
    endtask

    task automatic push16(input logic ill, input logic [2:0] f, input logic [7:0] p);
        q16.push_back({ill, f, p});
    endtask

    // Memory model: valid is raised once req has been high for dly8 cycles.
    always @(negedge clk) begin
        if (if8.imem_req) begin
            if (cnt8 == 0) a0_8 = if8.imem_addr;
            else chk("addr_hold8", if8.imem_addr, a0_8);
            if (cnt8 >= dly8) begin
                if8.imem_valid = 1'b1;
                if8.imem_rdata = mem8[if8.imem_addr];
            end
            cnt8++;
        end else begin
            if (cnt8 != 0 && rst8_n) chk("req_len8", cnt8, dly8 + 1);
            if8.imem_valid = 1'b0;
            cnt8 = 0;
        end
    end

    always @(negedge clk) begin
        if (if16.imem_req) begin
            if16.imem_valid = 1'b1;
            if16.imem_rdata = mem16[if16.imem_addr];
        end else begin
            if16.imem_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst8_n && retire8) begin
            if (q8.size() == 0) chk("extra_retire8", 1, 0);
            else begin
                e8 = q8.pop_front();
                chk("retire8", {ill8, flags8, pc8}, e8);
            end
        end
        if (rst16_n && retire16) begin
            if (q16.size() == 0) chk("extra_retire16", 1, 0);
            else begin
                e16 = q16.pop_front();
                chk("retire16", {ill16, flags16, pc16}, e16);
            end
        end
    end

    task automatic clear8();
        for (int i = 0; i < 256; i++) mem8[i] = '0;
    endtask

    task automatic start8();
        rst8_n = 1'b0;
        repeat (2) @(negedge clk);
        rst8_n = 1'b1;
    endtask

    task automatic run8(input int budget);
        int n = 0;
        while (!halted8 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!halted8) chk("timeout8", 0, 1);
        repeat (4) @(negedge clk);
        chk("sb_empty8", q8.size(), 0);
        chk("req_off8", if8.imem_req, 0);
    endtask

    task automatic reg8(input int r, input logic [7:0] exp, input string tag);
        dbg8 = 3'(r);
        #1;
        chk(tag, rdata8, exp);
    endtask

    task automatic reg16(input int r, input logic [15:0] exp, input string tag);
        dbg16 = 4'(r);
        #1;
        chk(tag, rdata16, exp);
    endtask

    initial begin
        if8.imem_valid  = 1'b0;
        if8.imem_rdata  = '0;
        if16.imem_valid = 1'b0;
        if16.imem_rdata = '0;
        for (int i = 0; i < 256; i++) mem16[i] = '0;
        clear8();
        repeat (2) @(negedge clk);
        chk("rst_req", if8.imem_req, 0);
        chk("rst_pc", pc8, 0);
        chk("rst_out", {retire8, ill8, halted8, flags8}, 0);

        // 1: MOVI/MOVI/ADD
        mem8[0] = i8(8, 1, 5); mem8[1] = i8(8, 2, 3); mem8[2] = i8(0, 1, 2); mem8[3] = i8(15, 0, 0);
        push8(0, 0, 1); push8(0, 0, 2); push8(0, 0, 3); push8(0, 0, 3);
        start8(); run8(200);
        reg8(1, 8, "t1_r1");
        chk("t1_state", {halted8, flags8, pc8}, {1'b1, 3'b000, 8'd3});

        // 2: SUB/JNZ countdown loop
        clear8();
        mem8[0] = i8(8, 1, 3); mem8[1] = i8(8, 2, 1); mem8[2] = i8(1, 1, 2);
        mem8[3] = i8(12, 0, 2); mem8[4] = i8(15, 0, 0);
        push8(0, 0, 1); push8(0, 0, 2); push8(0, 0, 3); push8(0, 0, 2); push8(0, 0, 3);
        push8(0, 0, 2); push8(0, 1, 3); push8(0, 1, 4); push8(0, 1, 4);
        start8(); run8(300);
        reg8(1, 0, "t2_r1");
        chk("t2_state", {halted8, flags8, pc8}, {1'b1, 3'b001, 8'd4});

        // 3: ADD carry-out, MUL overflow, CMP borrow/negative, untaken JZ
        clear8();
        mem8[0] = i8(8, 1, 255); mem8[1] = i8(8, 2, 1); mem8[2] = i8(0, 1, 2); mem8[3] = i8(8, 3, 16);
        mem8[4] = i8(2, 3, 3); mem8[5] = i8(9, 0, 2); mem8[6] = i8(11, 0, 0); mem8[7] = i8(15, 0, 0);
        push8(0, 0, 1); push8(0, 0, 2); push8(0, 3'b011, 3); push8(0, 3'b011, 4);
        push8(0, 3'b011, 5); push8(0, 3'b110, 6); push8(0, 3'b110, 7); push8(0, 3'b110, 7);
        start8(); run8(300);
        reg8(1, 0, "t3_r1");
        reg8(3, 0, "t3_r3");
        reg8(2, 1, "t3_r2");

        // 4: slow memory, illegal opcodes, NOT
        clear8();
        dly8 = 3;
        mem8[0] = i8(8, 1, 7); mem8[1] = i8(13, 0, 0); mem8[2] = i8(14, 5, 5);
        mem8[3] = i8(6, 1, 0); mem8[4] = i8(15, 0, 0);
        push8(0, 0, 1); push8(1, 0, 2); push8(1, 0, 3); push8(0, 3'b100, 4); push8(0, 3'b100, 4);
        start8(); run8(400);
        reg8(1, 8'hF8, "t4_r1");
        reg8(5, 0, "t4_r5");
        dly8 = 0;

        // 5: JMP to top of address space, pc wrap, taken JZ
        clear8();
        mem8[0] = i8(11, 0, 4); mem8[1] = i8(8, 1, 255); mem8[2] = i8(8, 2, 1);
        mem8[3] = i8(10, 0, 255); mem8[255] = i8(0, 1, 2); mem8[4] = i8(15, 0, 0);
        push8(0, 0, 1); push8(0, 0, 2); push8(0, 0, 3); push8(0, 0, 255);
        push8(0, 3'b011, 0); push8(0, 3'b011, 4); push8(0, 3'b011, 4);
        start8(); run8(300);
        reg8(1, 0, "t5_r1");

        // 5b: 16-bit / 16-register instance
        mem16[0] = i16(8, 1, 5); mem16[1] = i16(8, 2, 3); mem16[2] = i16(0, 1, 2);
        mem16[3] = i16(8, 9, 200); mem16[4] = i16(0, 9, 9); mem16[5] = i16(15, 0, 0);
        push16(0, 0, 1); push16(0, 0, 2); push16(0, 0, 3); push16(0, 0, 4); push16(0, 0, 5); push16(0, 0, 5);
        rst16_n = 1'b1;
        for (int n = 0; n < 200 && !halted16; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("t5_halt16", halted16, 1);
        chk("sb_empty16", q16.size(), 0);
        reg16(1, 8, "t5_r1_16");
        reg16(9, 400, "t5_r9_16");
        chk("t5_state16", {flags16, pc16}, {3'b000, 8'd5});

        // 6: async reset in the middle of a held fetch
        clear8();
        dly8 = 20;
        mem8[0] = i8(8, 1, 9); mem8[1] = i8(8, 3, 4);
        push8(0, 0, 1); push8(0, 0, 2);
        start8();
        for (int n = 0; n < 200 && q8.size() != 0; n++) @(negedge clk);
        chk("t6_sb", q8.size(), 0);
        repeat (5) @(negedge clk);
        chk("t6_req_held", if8.imem_req, 1);
        reg8(1, 9, "t6_r1_pre");
        #2;
        rst8_n = 1'b0;
        #1;
        chk("t6_req_drop", if8.imem_req, 0);
        chk("t6_pc", pc8, 0);
        chk("t6_out", {retire8, halted8, flags8}, 0);
        for (int r = 0; r < 8; r++) reg8(r, 0, "t6_reg");
        dly8 = 0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
